lpf_ctrl: RTL

LPF_CTRL -- requirements
Module: lpf_ctrl

---
 rtl/lpf_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/lpf_ctrl.sv
// lpf_ctrl: frame-level controller for a low-pass filter. It sequences
// enable/flush around one frame, drains the filter output buffer into a
// 2-entry skid FIFO and presents pixels downstream with valid/ready.
module lpf_ctrl #(
  parameter int FRAME_PIXELS = 307200,
  parameter int CNT_W        = 19
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_start,
  input  logic        i_cfg_en,
  output logic        o_lpf_enable,
  output logic        o_lpf_flush,
  input  logic        i_lpf_rd,
  input  logic        i_obuf_empty,
  input  logic [15:0] i_obuf_data,
  output logic        o_obuf_rd,
  output logic [15:0] o_data,
  output logic        o_valid,
  input  logic        i_ready,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_overrun
);

  localparam logic [CNT_W-1:0] FP    = CNT_W'(FRAME_PIXELS);
  localparam logic [CNT_W-1:0] FP_M1 = CNT_W'(FRAME_PIXELS - 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t            state, nxt;
  logic [CNT_W-1:0]  in_cnt, out_cnt, rd_issued;
  logic [1:0][15:0]  mem;
  logic              wr_ptr, rd_ptr;
  logic [1:0]        occ;
  logic              inflight;
  logic              start_ok, push, pop, in_last, draining;

  assign start_ok = (state == IDLE) && i_start && i_cfg_en;
  assign in_last  = (state == RUN) && i_lpf_rd && (in_cnt == FP_M1);
  assign draining = (state == RUN) || (state == FLUSH);
  // data for a read returns one cycle later, so a read in flight is a push
  assign push     = inflight;
  assign pop      = o_valid && i_ready;

  // a read is only issued when the skid is guaranteed room for its data
  assign o_obuf_rd = draining && !i_obuf_empty &&
                     ((occ + {1'b0, inflight}) < 2'd2) && (rd_issued < FP);
  assign o_valid   = (occ != 2'd0);
  assign o_data    = mem[rd_ptr];

  // state register
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state <= IDLE;
    else         state <= nxt;
  end

  // next-state decode
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start_ok)        nxt = RUN;
      RUN:     if (in_last)         nxt = FLUSH;
      FLUSH:   if (out_cnt == FP)   nxt = DONE;
      DONE:                         nxt = IDLE;
      default:                      nxt = IDLE;
    endcase
  end

  // control outputs registered from the next state so they track state exactly
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_lpf_enable <= 1'b0;
      o_lpf_flush  <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      o_lpf_enable <= (nxt == RUN) || (nxt == FLUSH);
      o_lpf_flush  <= (nxt == FLUSH);
      o_busy       <= (nxt != IDLE);
      o_done       <= (nxt == DONE);
      o_overrun    <= i_start && (state != IDLE);
    end
  end

  // pixel counters, cleared at frame start and saturating at frame size
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      in_cnt    <= '0;
      out_cnt   <= '0;
      rd_issued <= '0;
    end else if (start_ok) begin
      in_cnt    <= '0;
      out_cnt   <= '0;
      rd_issued <= '0;
    end else begin
      if ((state == RUN) && i_lpf_rd && (in_cnt != FP)) in_cnt <= in_cnt + 1'b1;
      if (pop && (out_cnt != FP))                       out_cnt <= out_cnt + 1'b1;
      if (o_obuf_rd && (rd_issued != FP))               rd_issued <= rd_issued + 1'b1;
    end
  end

  // 2-entry skid FIFO; push and pop in the same cycle leave occupancy unchanged
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      mem      <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      occ      <= 2'd0;
      inflight <= 1'b0;
    end else if (start_ok) begin
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      occ      <= 2'd0;
      inflight <= 1'b0;
    end else begin
      inflight <= o_obuf_rd;
      if (push) begin
        mem[wr_ptr] <= i_obuf_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

endmodule
